// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the regfile write port between ALU (req 0) and LSU (req 1)
//            with a registered write stage. Defining REGFILE_WB_ARB_FAIR_EN
//            selects round-robin arbitration; otherwise fixed ALU priority
//            with an LSU starvation limit is used.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module regfile_wb_arbiter #(
    parameter int WIDTH        = `WORD_WIDTH,
    parameter int REG_COUNT    = `REG_COUNT,
    parameter int ADDR_WIDTH   = $clog2(REG_COUNT),
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [WIDTH-1:0]      lsu_data,
    output logic [ADDR_WIDTH-1:0] addr_d,
    output logic [WIDTH-1:0]      d,
    output logic                  we_d
);

    logic                  grant_alu;
    logic                  grant_lsu;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0]      wr_data_q;
    logic                  wr_en_q;

`ifdef REGFILE_WB_ARB_FAIR_EN
    // last_grant_q: 1 = LSU was granted last; reset to LSU so ALU wins the first tie
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_lsu    = lsu_valid && (!alu_valid || !last_grant_q);
        grant_alu    = alu_valid && !grant_lsu;
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            last_grant_d = 1'b0;
        end else if (grant_lsu) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // LSU overrides ALU once it has waited STARVE_LIMIT cycles
    always_comb begin
        grant_lsu    = lsu_valid && (!alu_valid || (starve_cnt_q == C_STARVE_LIMIT));
        grant_alu    = alu_valid && !grant_lsu;
        starve_cnt_d = 4'd0;
        if (lsu_valid && !grant_lsu) begin
            starve_cnt_d = (starve_cnt_q == C_STARVE_LIMIT) ? starve_cnt_q
                                                             : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    // The write port drains every cycle, so grants never wait on wr_en_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= grant_alu || grant_lsu;
            if (grant_alu) begin
                wr_addr_q <= alu_addr;
                wr_data_q <= alu_data;
            end else if (grant_lsu) begin
                wr_addr_q <= lsu_addr;
                wr_data_q <= lsu_data;
            end
        end
    end

    assign addr_d = wr_addr_q;
    assign d      = wr_data_q;
    assign we_d   = wr_en_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Scoreboard bench for regfile_wb_arbiter; expected writes are
//            queued at grant time and popped by a monitor on each write.
// Revision : 1.0 - initial release
// ============================================================================

module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic [4:0]  addr_d;
    logic [31:0] d;
    logic        we_d;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] v;
    } wr_t;

    wr_t         sb[$];
    int          tests;
    int          fails;
    logic [31:0] tb_rf [32];

    regfile_wb_arbiter #(
        .WIDTH        (32),
        .REG_COUNT    (32),
        .ADDR_WIDTH   (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .addr_d    (addr_d),
        .d         (d),
        .we_d      (we_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple regfile model fed by the write port
    always @(posedge clk) begin
        if (rst_n && we_d) tb_rf[addr_d] <= d;
    end

    // Monitor: every write presented by the DUT must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && we_d) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", addr_d, d);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (addr_d !== e.a || d !== e.v) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             addr_d, d, e.a, e.v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One request cycle: drive, check readies against the expected grant, queue the expected write
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic ea, input logic el, input string name);
        wr_t e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        @(negedge clk);
        tests++;
        if (alu_ready !== ea || lsu_ready !== el) begin
            fails++;
            $display("FAIL %s: readies alu=%b lsu=%b, expected alu=%b lsu=%b",
                     name, alu_ready, lsu_ready, ea, el);
        end
        if (ea) begin
            e.a = aa; e.v = ad; sb.push_back(e);
        end else if (el) begin
            e.a = la; e.v = ld; sb.push_back(e);
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  pat;
        logic [4:0]  hold_a;
        logic [31:0] hold_v;
        logic [31:0] same_final;
        logic        same_first_alu;

        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) tb_rf[i] = 32'h0;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;

        #3;
        check("reset_outputs", {27'd0, we_d, addr_d, d}, 64'd0);
        check("reset_readies", {62'd0, alu_ready, lsu_ready}, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef REGFILE_WB_ARB_FAIR_EN
        pat            = 10'b0101010101;
        same_first_alu = 1'b0;
        same_final     = 32'd7;
`else
        pat            = 10'b0111101111;
        same_first_alu = 1'b1;
        same_final     = 32'd9;
`endif
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, pat[i], !pat[i], "contention");
        end

        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "drain");
        hold_a = addr_d;
        hold_v = d;
        check("drain_last_addr", {59'd0, hold_a}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "idle_ready");
            check("idle_port", {27'd0, we_d, addr_d, d}, {27'd0, 1'b0, hold_a, hold_v});
        end

        cycle(1'b1, 5'd5, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "single_alu");
        check("single_alu_we", {63'd0, we_d}, 64'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "single_alu_drain");
        check("rf5_readback", {32'd0, tb_rf[5]}, 64'h0000CAFE);

        cycle(1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 32'd9, same_first_alu, !same_first_alu, "same_addr_1");
        cycle(!same_first_alu, 5'd3, 32'd7, same_first_alu, 5'd3, 32'd9,
              !same_first_alu, same_first_alu, "same_addr_2");
        check("same_addr_we_cont", {63'd0, we_d}, 64'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "same_addr_drain");
        check("rf3_final", {32'd0, tb_rf[3]}, {32'd0, same_final});

        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, "single_lsu");
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "single_lsu_drain");
        check("rf9_readback", {32'd0, tb_rf[9]}, 64'h99);

        // Reset with a write staged: the write must be dropped
        cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "staged_write");
        check("staged_we", {63'd0, we_d}, 64'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_outputs", {27'd0, we_d, addr_d, d}, 64'd0);
        @(posedge clk);
        #1;
        check("rf7_not_written", {32'd0, tb_rf[7]}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, "post_reset_first_tie");
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "final_drain");
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
